tile_sequencer: RTL and testbench

- Parametrised successor to the layer main controller.
- Walks a feature map tile by tile (x, y) and, per tile, through output-channel partitions. For each step it issues DMA and compute-engine commands: load input tile, load kernel partition, compute (1x1, optionally followed by depthwise), write output tile.
- Adds over the previous controller: configurable widths, edge-tile clipping, stride-2 output sizing, optional depthwise stage, base addresses, latched configuration, busy flag.

---
 rtl/tile_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_tile_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_sequencer.sv
// rtl/tile_sequencer.sv - tiled feature-map sequencer issuing DMA and compute commands
module tile_sequencer #(
    parameter int AW  = 32,
    parameter int DW  = 11,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [DW-1:0]  cfg_fm_w,
    input  logic [DW-1:0]  cfg_fm_h,
    input  logic [DW-1:0]  cfg_tile_w,
    input  logic [DW-1:0]  cfg_tile_h,
    input  logic [DW-1:0]  cfg_n_ch,
    input  logic [DW-1:0]  cfg_n_part,
    input  logic [DW-1:0]  cfg_part_step,
    input  logic           cfg_stride2,
    input  logic           cfg_mode_dw,
    input  logic [AW-1:0]  cfg_base_i,
    input  logic [AW-1:0]  cfg_base_k,
    input  logic [AW-1:0]  cfg_base_o,
    input  logic           dma_done,
    input  logic           cmp_done,
    output logic           dma_start,
    output logic [OPW-1:0] dma_op,
    output logic [AW-1:0]  dma_info1,
    output logic [AW-1:0]  dma_info2,
    output logic [AW-1:0]  dma_addr,
    output logic           cmp_start,
    output logic           cmp_op,
    output logic           busy,
    output logic           finish
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_FMI, S_LD_KER, S_CMP11, S_CMPDW, S_WR, S_NEXT, S_FINISH
    } state_t;

    localparam logic [OPW-1:0] OP_FMI = OPW'(1);
    localparam logic [OPW-1:0] OP_KER = OPW'(2);
    localparam logic [OPW-1:0] OP_WR  = OPW'(5);

    state_t        state;
    logic [DW-1:0] fm_w_q, fm_h_q, tile_w_q, tile_h_q, n_ch_q, n_part_q, part_step_q;
    logic          stride2_q, mode_dw_q;
    logic [AW-1:0] base_i_q, base_k_q, base_o_q;
    logic [DW-1:0] tx_q, ty_q, part_q;

    // Effective config: live inputs while IDLE so the first command issues on the start edge
    logic [DW-1:0] c_fm_w, c_fm_h, c_tile_w, c_tile_h, c_n_ch, c_n_part, c_step;
    logic          c_s2;
    logic [AW-1:0] c_base_i, c_base_k, c_base_o;
    logic [DW-1:0] n_tx, n_ty, n_part;
    logic          go_ker, go_fmi;
    logic [DW-1:0] rem_w, rem_h, rem_p, cw, ch, pw;
    logic [AW-1:0] fmi_addr, ker_addr, wr_addr;
    logic          dma_done_v, cmp_done_v;

    always_comb begin
        c_fm_w   = (state == S_IDLE) ? cfg_fm_w      : fm_w_q;
        c_fm_h   = (state == S_IDLE) ? cfg_fm_h      : fm_h_q;
        c_tile_w = (state == S_IDLE) ? cfg_tile_w    : tile_w_q;
        c_tile_h = (state == S_IDLE) ? cfg_tile_h    : tile_h_q;
        c_n_ch   = (state == S_IDLE) ? cfg_n_ch      : n_ch_q;
        c_n_part = (state == S_IDLE) ? cfg_n_part    : n_part_q;
        c_step   = (state == S_IDLE) ? cfg_part_step : part_step_q;
        c_s2     = (state == S_IDLE) ? cfg_stride2   : stride2_q;
        c_base_i = (state == S_IDLE) ? cfg_base_i    : base_i_q;
        c_base_k = (state == S_IDLE) ? cfg_base_k    : base_k_q;
        c_base_o = (state == S_IDLE) ? cfg_base_o    : base_o_q;

        n_tx   = tx_q;
        n_ty   = ty_q;
        n_part = part_q;
        go_ker = 1'b0;
        go_fmi = 1'b0;
        if (state == S_IDLE) begin
            n_tx   = '0;
            n_ty   = '0;
            n_part = '0;
        end else if (state == S_NEXT) begin
            if (({1'b0, part_q} + {1'b0, c_step}) < {1'b0, c_n_part}) begin
                n_part = part_q + c_step;
                go_ker = 1'b1;
            end else begin
                n_part = '0;
                if (({1'b0, tx_q} + {1'b0, c_tile_w}) < {1'b0, c_fm_w}) begin
                    n_tx   = tx_q + c_tile_w;
                    go_fmi = 1'b1;
                end else begin
                    n_tx = '0;
                    if (({1'b0, ty_q} + {1'b0, c_tile_h}) < {1'b0, c_fm_h}) begin
                        n_ty   = ty_q + c_tile_h;
                        go_fmi = 1'b1;
                    end
                end
            end
        end

        // Edge clipping; counters never pass their limits so these cannot underflow
        rem_w = c_fm_w - n_tx;
        rem_h = c_fm_h - n_ty;
        rem_p = c_n_part - n_part;
        cw    = (c_tile_w < rem_w) ? c_tile_w : rem_w;
        ch    = (c_tile_h < rem_h) ? c_tile_h : rem_h;
        pw    = (c_step < rem_p) ? c_step : rem_p;

        fmi_addr = c_base_i + AW'(n_ty) * AW'(c_fm_w) + AW'(n_tx);
        ker_addr = c_base_k + AW'(n_part) * AW'(c_n_ch);
        wr_addr  = c_base_o + AW'(n_ty >> c_s2) * AW'(c_fm_w >> c_s2) + AW'(n_tx >> c_s2);

        dma_done_v = dma_done && !dma_start;
        cmp_done_v = cmp_done && !cmp_start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            fm_w_q      <= '0;
            fm_h_q      <= '0;
            tile_w_q    <= '0;
            tile_h_q    <= '0;
            n_ch_q      <= '0;
            n_part_q    <= '0;
            part_step_q <= '0;
            stride2_q   <= 1'b0;
            mode_dw_q   <= 1'b0;
            base_i_q    <= '0;
            base_k_q    <= '0;
            base_o_q    <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            part_q      <= '0;
            dma_start   <= 1'b0;
            dma_op      <= '0;
            dma_info1   <= '0;
            dma_info2   <= '0;
            dma_addr    <= '0;
            cmp_start   <= 1'b0;
            cmp_op      <= 1'b0;
            busy        <= 1'b0;
            finish      <= 1'b0;
        end else begin
            dma_start <= 1'b0;
            cmp_start <= 1'b0;
            finish    <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    fm_w_q      <= cfg_fm_w;
                    fm_h_q      <= cfg_fm_h;
                    tile_w_q    <= cfg_tile_w;
                    tile_h_q    <= cfg_tile_h;
                    n_ch_q      <= cfg_n_ch;
                    n_part_q    <= cfg_n_part;
                    part_step_q <= cfg_part_step;
                    stride2_q   <= cfg_stride2;
                    mode_dw_q   <= cfg_mode_dw;
                    base_i_q    <= cfg_base_i;
                    base_k_q    <= cfg_base_k;
                    base_o_q    <= cfg_base_o;
                    tx_q        <= '0;
                    ty_q        <= '0;
                    part_q      <= '0;
                    busy        <= 1'b1;
                    state       <= S_LD_FMI;
                    dma_start   <= 1'b1;
                    dma_op      <= OP_FMI;
                    dma_info1   <= AW'(cw);
                    dma_info2   <= AW'(ch);
                    dma_addr    <= fmi_addr;
                end
                S_LD_FMI: if (dma_done_v) begin
                    state     <= S_LD_KER;
                    dma_start <= 1'b1;
                    dma_op    <= OP_KER;
                    dma_info1 <= AW'(pw);
                    dma_info2 <= AW'(c_n_ch);
                    dma_addr  <= ker_addr;
                end
                S_LD_KER: if (dma_done_v) begin
                    state     <= S_CMP11;
                    cmp_start <= 1'b1;
                    cmp_op    <= 1'b0;
                end
                S_CMP11: if (cmp_done_v) begin
                    if (mode_dw_q) begin
                        state     <= S_CMPDW;
                        cmp_start <= 1'b1;
                        cmp_op    <= 1'b1;
                    end else begin
                        state     <= S_WR;
                        dma_start <= 1'b1;
                        dma_op    <= OP_WR;
                        dma_info1 <= AW'(cw >> c_s2);
                        dma_info2 <= AW'(ch >> c_s2);
                        dma_addr  <= wr_addr;
                    end
                end
                S_CMPDW: if (cmp_done_v) begin
                    state     <= S_WR;
                    dma_start <= 1'b1;
                    dma_op    <= OP_WR;
                    dma_info1 <= AW'(cw >> c_s2);
                    dma_info2 <= AW'(ch >> c_s2);
                    dma_addr  <= wr_addr;
                end
                S_WR: if (dma_done_v) state <= S_NEXT;
                S_NEXT: begin
                    tx_q   <= n_tx;
                    ty_q   <= n_ty;
                    part_q <= n_part;
                    if (go_ker) begin
                        state     <= S_LD_KER;
                        dma_start <= 1'b1;
                        dma_op    <= OP_KER;
                        dma_info1 <= AW'(pw);
                        dma_info2 <= AW'(c_n_ch);
                        dma_addr  <= ker_addr;
                    end else if (go_fmi) begin
                        state     <= S_LD_FMI;
                        dma_start <= 1'b1;
                        dma_op    <= OP_FMI;
                        dma_info1 <= AW'(cw);
                        dma_info2 <= AW'(ch);
                        dma_addr  <= fmi_addr;
                    end else begin
                        state  <= S_FINISH;
                        finish <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_sequencer.sv
// tb/tb_tile_sequencer.sv - table-driven and randomized checks of tile_sequencer against a loop-nest model
module tb_tile_sequencer;
    localparam int AW = 32, DW = 11, OPW = 3;

    logic clk = 1'b0;
    logic rst, start, cfg_stride2, cfg_mode_dw, dma_done, cmp_done;
    logic [DW-1:0] cfg_fm_w, cfg_fm_h, cfg_tile_w, cfg_tile_h, cfg_n_ch, cfg_n_part, cfg_part_step;
    logic [AW-1:0] cfg_base_i, cfg_base_k, cfg_base_o;
    logic dma_start, cmp_start, cmp_op, busy, finish;
    logic [OPW-1:0] dma_op;
    logic [AW-1:0] dma_info1, dma_info2, dma_addr;

    always #5 clk = ~clk;

    tile_sequencer #(.AW(AW), .DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_fm_w(cfg_fm_w), .cfg_fm_h(cfg_fm_h), .cfg_tile_w(cfg_tile_w), .cfg_tile_h(cfg_tile_h),
        .cfg_n_ch(cfg_n_ch), .cfg_n_part(cfg_n_part), .cfg_part_step(cfg_part_step),
        .cfg_stride2(cfg_stride2), .cfg_mode_dw(cfg_mode_dw),
        .cfg_base_i(cfg_base_i), .cfg_base_k(cfg_base_k), .cfg_base_o(cfg_base_o),
        .dma_done(dma_done), .cmp_done(cmp_done),
        .dma_start(dma_start), .dma_op(dma_op), .dma_info1(dma_info1), .dma_info2(dma_info2),
        .dma_addr(dma_addr), .cmp_start(cmp_start), .cmp_op(cmp_op), .busy(busy), .finish(finish)
    );

    typedef struct {
        int fm_w, fm_h, tile_w, tile_h, n_ch, n_part, step;
        bit s2, dw;
        logic [31:0] bi, bk, bo;
    } cfg_t;
    typedef struct {
        cfg_t c;
        int e_fmi, e_ker, e_cmp, e_wr;
    } vec_t;
    typedef struct {
        bit is_cmp;
        int op;
        logic [31:0] i1, i2, addr;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(string name, longint act, longint req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void push_ev(bit is_cmp, int op, logic [31:0] i1, logic [31:0] i2, logic [31:0] addr);
        ev_t e;
        e.is_cmp = is_cmp; e.op = op; e.i1 = i1; e.i2 = i2; e.addr = addr;
        exp_q.push_back(e);
    endfunction

    // Reference: the command stream is just the nested loop over tile rows, tile columns and partitions
    function automatic void build_model(cfg_t c);
        int s;
        s = c.s2 ? 1 : 0;
        exp_q.delete();
        for (int ty = 0; ty < c.fm_h; ty += c.tile_h) begin
            for (int tx = 0; tx < c.fm_w; tx += c.tile_w) begin
                int cw, ch, part;
                cw = (c.fm_w - tx < c.tile_w) ? c.fm_w - tx : c.tile_w;
                ch = (c.fm_h - ty < c.tile_h) ? c.fm_h - ty : c.tile_h;
                push_ev(0, 1, cw, ch, c.bi + ty * c.fm_w + tx);
                part = 0;
                do begin
                    int pw;
                    pw = (c.n_part - part < c.step) ? c.n_part - part : c.step;
                    push_ev(0, 2, pw, c.n_ch, c.bk + part * c.n_ch);
                    push_ev(1, 0, 0, 0, 0);
                    if (c.dw) push_ev(1, 1, 0, 0, 0);
                    push_ev(0, 5, cw >> s, ch >> s, c.bo + (ty >> s) * (c.fm_w >> s) + (tx >> s));
                    part += c.step;
                end while (part < c.n_part);
            end
        end
    endfunction

    task automatic drive_cfg(cfg_t c);
        cfg_fm_w = DW'(c.fm_w); cfg_fm_h = DW'(c.fm_h);
        cfg_tile_w = DW'(c.tile_w); cfg_tile_h = DW'(c.tile_h);
        cfg_n_ch = DW'(c.n_ch); cfg_n_part = DW'(c.n_part); cfg_part_step = DW'(c.step);
        cfg_stride2 = c.s2; cfg_mode_dw = c.dw;
        cfg_base_i = c.bi; cfg_base_k = c.bk; cfg_base_o = c.bo;
    endtask

    task automatic scramble_cfg();
        cfg_fm_w = DW'($urandom); cfg_fm_h = DW'($urandom);
        cfg_tile_w = DW'($urandom); cfg_tile_h = DW'($urandom);
        cfg_n_ch = DW'($urandom); cfg_n_part = DW'($urandom); cfg_part_step = DW'($urandom);
        cfg_stride2 = 1'($urandom); cfg_mode_dw = 1'($urandom);
        cfg_base_i = $urandom; cfg_base_k = $urandom; cfg_base_o = $urandom;
    endtask

    // Runs one layer as a responder: records every strobe, answers with a delayed done pulse
    task automatic run_cfg(string tag, cfg_t c, bit early, bit disturb, bit abort_cmp,
                           output int nf, output int nk, output int nc, output int nw);
        int pend, cnt, cyc, overlap, stray;
        bit pend_cmp, seen_fin;
        ev_t e;
        pend = 0; cnt = 0; cyc = 0; overlap = 0; stray = 0; pend_cmp = 0; seen_fin = 0;
        nf = 0; nk = 0; nc = 0; nw = 0;
        build_model(c);
        obs_q.delete();
        @(negedge clk);
        drive_cfg(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_first_strobe"}, {dma_start, dma_op}, {1'b1, 3'd1});
        if (disturb) scramble_cfg();
        while (!seen_fin && cyc < 20000) begin
            dma_done = 1'b0;
            cmp_done = 1'b0;
            start = 1'b0;
            if (dma_start || cmp_start) begin
                if (pend != 0) overlap++;
                e.is_cmp = cmp_start;
                e.op = cmp_start ? int'(cmp_op) : int'(dma_op);
                e.i1 = dma_info1; e.i2 = dma_info2; e.addr = dma_addr;
                obs_q.push_back(e);
                pend = 1; pend_cmp = cmp_start; cnt = $urandom_range(1, 4);
                if (early) begin
                    if (cmp_start) cmp_done = 1'b1;
                    else dma_done = 1'b1;
                end
                if (abort_cmp && cmp_start) return;
            end else if (pend != 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (pend_cmp) cmp_done = 1'b1;
                    else dma_done = 1'b1;
                    pend = 0;
                end else if (disturb && $urandom_range(0, 1) == 1) begin
                    if (pend_cmp) dma_done = 1'b1;
                    else cmp_done = 1'b1;
                end
            end
            if (finish) seen_fin = 1;
            if (disturb && cyc == 3) start = 1'b1;
            cyc++;
            if (!seen_fin) @(negedge clk);
        end
        dma_done = 1'b0; cmp_done = 1'b0; start = 1'b0;
        check({tag, "_finish_seen"}, seen_fin, 1);
        check({tag, "_strobe_overlap"}, overlap, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, "_busy_after_finish"}, busy, 0);
            stray += int'(finish) + int'(dma_start) + int'(cmp_start);
        end
        check({tag, "_quiet_after_finish"}, stray, 0);
        check({tag, "_event_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            bit ok;
            ok = (obs_q[i].is_cmp == exp_q[i].is_cmp) && (obs_q[i].op == exp_q[i].op);
            if (!exp_q[i].is_cmp)
                ok = ok && (obs_q[i].i1 === exp_q[i].i1) && (obs_q[i].i2 === exp_q[i].i2)
                        && (obs_q[i].addr === exp_q[i].addr);
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s_event[%0d]: got cmp=%0d op=%0d i1=%0d i2=%0d addr=%0h, expected cmp=%0d op=%0d i1=%0d i2=%0d addr=%0h",
                         tag, i, obs_q[i].is_cmp, obs_q[i].op, obs_q[i].i1, obs_q[i].i2, obs_q[i].addr,
                         exp_q[i].is_cmp, exp_q[i].op, exp_q[i].i1, exp_q[i].i2, exp_q[i].addr);
            end
        end
        foreach (obs_q[i]) begin
            if (!obs_q[i].is_cmp && obs_q[i].op == 1) nf++;
            if (!obs_q[i].is_cmp && obs_q[i].op == 2) nk++;
            if (obs_q[i].is_cmp) nc++;
            if (!obs_q[i].is_cmp && obs_q[i].op == 5) nw++;
        end
    endtask

    vec_t vecs[6];

    initial begin
        int nf, nk, nc, nw;
        cfg_t c;

        vecs[0] = '{'{8, 8, 4, 4, 16, 2, 1, 0, 0, 32'd0, 32'd0, 32'd0}, 4, 8, 8, 8};
        vecs[1] = '{'{10, 4, 4, 4, 8, 1, 1, 0, 0, 32'd0, 32'd0, 32'd0}, 3, 3, 3, 3};
        vecs[2] = '{'{8, 8, 4, 4, 16, 2, 1, 1, 0, 32'd0, 32'd0, 32'd0}, 4, 8, 8, 8};
        vecs[3] = '{'{4, 4, 4, 4, 8, 1, 1, 0, 1, 32'd0, 32'd0, 32'd0}, 1, 1, 2, 1};
        vecs[4] = '{'{5, 3, 4, 2, 7, 0, 3, 0, 0, 32'd10, 32'd20, 32'd30}, 4, 4, 4, 4};
        vecs[5] = '{'{13, 7, 5, 3, 3, 10, 4, 1, 1, 32'd100, 32'd2000, 32'hFFFF_FFF0}, 9, 27, 54, 27};

        rst = 1'b1; start = 1'b0; dma_done = 1'b0; cmp_done = 1'b0;
        drive_cfg(vecs[0].c);
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_strobes", {dma_start, cmp_start, finish, cmp_op}, 0);
        check("reset_dma_fields", dma_op | dma_info1 | dma_info2 | dma_addr, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_cfg($sformatf("vec%0d", i), vecs[i].c, 1'b0, (i % 2) == 1, 1'b0, nf, nk, nc, nw);
            check($sformatf("vec%0d_n_fmi", i), nf, vecs[i].e_fmi);
            check($sformatf("vec%0d_n_ker", i), nk, vecs[i].e_ker);
            check($sformatf("vec%0d_n_cmp", i), nc, vecs[i].e_cmp);
            check($sformatf("vec%0d_n_wr", i), nw, vecs[i].e_wr);
        end

        for (int r = 0; r < 6; r++) begin
            c.fm_w = $urandom_range(1, 16); c.fm_h = $urandom_range(1, 10);
            c.tile_w = $urandom_range(2, 8); c.tile_h = $urandom_range(2, 8);
            c.n_ch = $urandom_range(0, 50); c.n_part = $urandom_range(0, 5);
            c.step = $urandom_range(1, 3);
            c.s2 = 1'($urandom); c.dw = 1'($urandom);
            c.bi = $urandom; c.bk = $urandom; c.bo = $urandom;
            run_cfg($sformatf("rand%0d", r), c, r[0], 1'b1, 1'b0, nf, nk, nc, nw);
        end

        run_cfg("early_done", vecs[0].c, 1'b1, 1'b1, 1'b0, nf, nk, nc, nw);
        check("early_done_n_fmi", nf, 4);
        check("early_done_n_ker", nk, 8);
        check("early_done_n_cmp", nc, 8);
        check("early_done_n_wr", nw, 8);

        run_cfg("abort", vecs[5].c, 1'b0, 1'b0, 1'b1, nf, nk, nc, nw);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_strobes", {dma_start, cmp_start, finish, cmp_op}, 0);
        check("abort_dma_fields", dma_op | dma_info1 | dma_info2 | dma_addr, 0);
        @(negedge clk);
        check("abort_held_quiet", {busy, dma_start, cmp_start, finish}, 0);
        rst = 1'b0;
        c = vecs[1].c;
        c.bi = 32'd500; c.bk = 32'd600; c.bo = 32'd700; c.n_part = 3; c.step = 2;
        run_cfg("after_abort", c, 1'b0, 1'b0, 1'b0, nf, nk, nc, nw);
        check("after_abort_n_fmi", nf, 3);
        check("after_abort_n_ker", nk, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
